// File: rtl/nvdla_sdp_pack_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nvdla_sdp_pack_pkg : shared widths and helpers for SDP pack/split blocks  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package nvdla_sdp_pack_pkg;

  localparam int SEG_CNT_W = 4;
  localparam int NSEG_W    = 5;

  function automatic bit legal_ratio(input int r);
    return (r == 1) || (r == 2) || (r == 4) || (r == 8) || (r == 16);
  endfunction

  // A zero or oversized request means "the whole wide word".
  function automatic logic [NSEG_W-1:0] norm_nseg(input logic [NSEG_W-1:0] n, input int ratio);
    if ((n == '0) || (int'(n) > ratio)) return NSEG_W'(ratio);
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nvdla_sdp_seg_mux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nvdla_sdp_seg_mux : selects one IW-bit segment out of an OW-bit word      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module nvdla_sdp_seg_mux
  import nvdla_sdp_pack_pkg::*;
#(
  parameter int OW    = 512,
  parameter int IW    = 128,
  parameter int SEL_W = SEG_CNT_W
) (
  input  logic [OW-1:0]    in_data,
  input  logic [SEL_W-1:0] sel,
  output logic [IW-1:0]    out_data
);

  localparam int NSEG = OW / IW;

  always_comb begin
    out_data = in_data[IW-1:0];
    for (int k = 0; k < NSEG; k++) begin
      if (sel == SEL_W'(k)) out_data = in_data[k*IW +: IW];
    end
  end

endmodule
`default_nettype wire

// File: rtl/nvdla_sdp_core_split.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nvdla_sdp_core_split : wide-to-narrow splitter, LS segment first          |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module nvdla_sdp_core_split
  import nvdla_sdp_pack_pkg::*;
#(
  parameter int OW    = 512,
  parameter int IW    = 128,
  parameter int RATIO = OW / IW
) (
  input  logic              nvdla_core_clk,
  input  logic              nvdla_core_rst,
  input  logic              inp_pvld,
  output logic              inp_prdy,
  input  logic [OW-1:0]     inp_data,
  input  logic [NSEG_W-1:0] inp_nseg,
  output logic              out_pvld,
  input  logic              out_prdy,
  output logic [IW-1:0]     out_data,
  output logic              out_last
);

  generate
    if (!legal_ratio(RATIO) || (RATIO * IW != OW)) begin : g_bad_ratio
      $error("nvdla_sdp_core_split: OW/IW must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  logic                 hold_vld_q,  hold_vld_d;
  logic [OW-1:0]        hold_data_q, hold_data_d;
  logic [NSEG_W-1:0]    hold_nseg_q, hold_nseg_d;
  logic [SEG_CNT_W-1:0] seg_cnt_q,   seg_cnt_d;

  logic is_last;
  logic inp_acc;
  logic out_acc;

  assign is_last  = ({1'b0, seg_cnt_q} == (hold_nseg_q - NSEG_W'(1)));
  assign out_pvld = hold_vld_q;
  assign out_last = hold_vld_q & is_last;
  // Ready looks through to out_prdy so a new word can replace the last segment without a bubble.
  assign inp_prdy = !hold_vld_q | (out_prdy & is_last);
  assign inp_acc  = inp_pvld & inp_prdy;
  assign out_acc  = hold_vld_q & out_prdy;

  always_comb begin
    hold_vld_d  = hold_vld_q;
    hold_data_d = hold_data_q;
    hold_nseg_d = hold_nseg_q;
    seg_cnt_d   = seg_cnt_q;
    if (out_acc) begin
      if (is_last) begin
        hold_vld_d = 1'b0;
        seg_cnt_d  = '0;
      end else begin
        seg_cnt_d = seg_cnt_q + SEG_CNT_W'(1);
      end
    end
    if (inp_acc) begin
      hold_vld_d  = 1'b1;
      hold_data_d = inp_data;
      hold_nseg_d = norm_nseg(inp_nseg, RATIO);
      seg_cnt_d   = '0;
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      hold_vld_q  <= 1'b0;
      hold_nseg_q <= NSEG_W'(RATIO);
      seg_cnt_q   <= '0;
    end else begin
      hold_vld_q  <= hold_vld_d;
      hold_nseg_q <= hold_nseg_d;
      seg_cnt_q   <= seg_cnt_d;
    end
  end

  // Payload is qualified by hold_vld, so it needs no reset.
  always_ff @(posedge nvdla_core_clk) begin
    hold_data_q <= hold_data_d;
  end

  nvdla_sdp_seg_mux #(
    .OW    (OW),
    .IW    (IW),
    .SEL_W (SEG_CNT_W)
  ) u_seg_mux (
    .in_data  (hold_data_q),
    .sel      (seg_cnt_q),
    .out_data (out_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_nvdla_sdp_core_split.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_nvdla_sdp_core_split : directed and scoreboarded checks of the split   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_nvdla_sdp_core_split;

  logic         clk = 1'b0;
  logic         rst;
  logic         inp_pvld, inp_prdy;
  logic [511:0] inp_data;
  logic [4:0]   inp_nseg;
  logic         out_pvld, out_prdy, out_last;
  logic [127:0] out_data;

  logic         p1_in_pvld, p1_in_prdy;
  logic [127:0] p1_in_data;
  logic [4:0]   p1_in_nseg;
  logic         p1_out_pvld, p1_out_prdy, p1_out_last;
  logic [127:0] p1_out_data;

  always #5 clk = ~clk;

  nvdla_sdp_core_split #(.OW(512), .IW(128)) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .inp_pvld       (inp_pvld),
    .inp_prdy       (inp_prdy),
    .inp_data       (inp_data),
    .inp_nseg       (inp_nseg),
    .out_pvld       (out_pvld),
    .out_prdy       (out_prdy),
    .out_data       (out_data),
    .out_last       (out_last)
  );

  nvdla_sdp_core_split #(.OW(128), .IW(128)) dut1 (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .inp_pvld       (p1_in_pvld),
    .inp_prdy       (p1_in_prdy),
    .inp_data       (p1_in_data),
    .inp_nseg       (p1_in_nseg),
    .out_pvld       (p1_out_pvld),
    .out_prdy       (p1_out_prdy),
    .out_data       (p1_out_data),
    .out_last       (p1_out_last)
  );

  typedef struct packed {
    logic [127:0] d;
    logic         last;
  } seg_t;

  seg_t         exp_q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           first_out = -1;
  int           last_out = -1;
  logic         prev_stall = 1'b0;
  logic [127:0] prev_data = '0;
  logic         prev_last = 1'b0;
  bit           rand_prdy = 1'b0;
  bit           acc;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic [511:0] d, input logic [4:0] nseg);
    int n;
    seg_t s;
    n = (nseg == 5'd0 || nseg > 5'd4) ? 4 : int'(nseg);
    for (int k = 0; k < n; k++) begin
      s.d    = d[k*128 +: 128];
      s.last = (k == n - 1);
      exp_q.push_back(s);
    end
  endtask

  task automatic monitor(output bit in_acc);
    seg_t e;
    cyc++;
    in_acc = 1'b0;
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("stall_pvld", out_pvld, 1);
        check_eq("stall_data", out_data, prev_data);
        check_eq("stall_last", out_last, prev_last);
      end
      if (out_pvld && out_prdy) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_seg", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_eq("seg_data", out_data, e.d);
          check_eq("seg_last", out_last, e.last);
        end
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
      end
      prev_stall = out_pvld && !out_prdy;
      prev_data  = out_data;
      prev_last  = out_last;
      if (inp_pvld && inp_prdy) begin
        push_word(inp_data, inp_nseg);
        in_acc = 1'b1;
      end
    end
  endtask

  task automatic tick(output bit in_acc);
    #3;
    monitor(in_acc);
    @(posedge clk);
    #1;
    if (rand_prdy) out_prdy = 1'($urandom_range(0, 1));
  endtask

  task automatic send_word(input logic [511:0] d, input logic [4:0] nseg);
    bit a;
    int g;
    a = 1'b0;
    g = 0;
    inp_pvld = 1'b1;
    inp_data = d;
    inp_nseg = nseg;
    while (!a && g < 200) begin
      tick(a);
      g++;
    end
    if (!a) check_eq("send_timeout", 0, 1);
  endtask

  task automatic drain();
    bit a;
    int g;
    g = 0;
    inp_pvld = 1'b0;
    while (exp_q.size() != 0 && g < 5000) begin
      tick(a);
      g++;
    end
    check_eq("drain_left", 128'(exp_q.size()), 0);
  endtask

  function automatic logic [511:0] rand_word();
    logic [511:0] w;
    for (int i = 0; i < 16; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic logic [127:0] p1_word(input int i);
    return {96'h0, 32'hC0DE_0000 + 32'(i)};
  endfunction

  logic [127:0] t1_exp [4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    t1_exp[0] = 128'h00000000000000000000000000000000;
    t1_exp[1] = 128'h11111111111111111111111111111111;
    t1_exp[2] = 128'h22222222222222222222222222222222;
    t1_exp[3] = 128'h33333333333333333333333333333333;

    rst = 1'b1;
    inp_pvld = 1'b0; inp_data = '0; inp_nseg = '0; out_prdy = 1'b1;
    p1_in_pvld = 1'b0; p1_in_data = '0; p1_in_nseg = '0; p1_out_prdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    #3;
    check_eq("rst_pvld", out_pvld, 0);
    check_eq("rst_last", out_last, 0);
    check_eq("rst_prdy", inp_prdy, 1);
    check_eq("rst_p1_pvld", p1_out_pvld, 0);
    check_eq("rst_p1_last", p1_out_last, 0);
    @(posedge clk);
    #1;

    // Single full word, nseg=0
    send_word({t1_exp[3], t1_exp[2], t1_exp[1], t1_exp[0]}, 5'd0);
    inp_pvld = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #3;
      check_eq("t1_pvld", out_pvld, 1);
      check_eq("t1_data", out_data, t1_exp[k]);
      check_eq("t1_last", out_last, (k == 3));
      check_eq("t1_inp_prdy", inp_prdy, (k == 3));
      monitor(acc);
      @(posedge clk);
      #1;
    end
    #3;
    check_eq("t1_idle_pvld", out_pvld, 0);
    check_eq("t1_idle_prdy", inp_prdy, 1);
    monitor(acc);
    @(posedge clk);
    #1;

    // Three words back to back: 12 segments with no gap
    first_out = -1;
    for (int w = 0; w < 3; w++) send_word(rand_word(), 5'd4);
    drain();
    check_eq("t2_span", 128'(last_out - first_out), 11);

    // Partial tails: 2+1+4+4 segments, nseg=7 behaves as 4
    first_out = -1;
    send_word(rand_word(), 5'd2);
    send_word(rand_word(), 5'd1);
    send_word(rand_word(), 5'd4);
    send_word(rand_word(), 5'd7);
    drain();
    check_eq("t3_span", 128'(last_out - first_out), 10);

    // Random backpressure over many words
    rand_prdy = 1'b1;
    for (int w = 0; w < 1000; w++) begin
      if ($urandom_range(0, 4) == 0) begin
        inp_pvld = 1'b0;
        tick(acc);
      end
      send_word(rand_word(), 5'($urandom_range(0, 20)));
    end
    drain();
    rand_prdy = 1'b0;
    out_prdy = 1'b1;

    // Reset after segment 1 of a word
    send_word(rand_word(), 5'd4);
    inp_pvld = 1'b0;
    tick(acc);
    tick(acc);
    rst = 1'b1;
    tick(acc);
    rst = 1'b0;
    #3;
    check_eq("t5_pvld", out_pvld, 0);
    check_eq("t5_prdy", inp_prdy, 1);
    check_eq("t5_last", out_last, 0);
    monitor(acc);
    @(posedge clk);
    #1;
    send_word(rand_word(), 5'd3);
    drain();

    // RATIO=1 instance: one-deep pipe, full throughput
    for (int i = 0; i < 5; i++) begin
      p1_in_pvld = (i < 4);
      p1_in_data = p1_word(i);
      #3;
      check_eq("t6_prdy", p1_in_prdy, 1);
      check_eq("t6_pvld", p1_out_pvld, (i > 0));
      check_eq("t6_last", p1_out_last, (i > 0));
      if (i > 0) check_eq("t6_data", p1_out_data, p1_word(i - 1));
      @(posedge clk);
      #1;
    end
    p1_in_pvld = 1'b1;
    p1_in_data = p1_word(5);
    @(posedge clk);
    #1;
    p1_in_data = p1_word(6);
    p1_out_prdy = 1'b0;
    for (int s = 0; s < 2; s++) begin
      #3;
      check_eq("t6_stall_prdy", p1_in_prdy, 0);
      check_eq("t6_stall_data", p1_out_data, p1_word(5));
      check_eq("t6_stall_last", p1_out_last, 1);
      @(posedge clk);
      #1;
    end
    p1_out_prdy = 1'b1;
    #3;
    check_eq("t6_release_prdy", p1_in_prdy, 1);
    @(posedge clk);
    #1;
    p1_in_pvld = 1'b0;
    #3;
    check_eq("t6_w6_data", p1_out_data, p1_word(6));
    check_eq("t6_w6_last", p1_out_last, 1);
    @(posedge clk);
    #1;
    #3;
    check_eq("t6_empty", p1_out_pvld, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
